// File: rtl/pattern_scheduler.sv
// Beat-driven pattern sequencer: advances the active pattern every BEATS_PER_STEP beats
// or on a manual request, and commits each change only at a frame boundary.
module pattern_scheduler #(
    parameter int NUM_PATTERNS   = 8,
    parameter int SEL_W          = 3,
    parameter int BEATS_PER_STEP = 4,
    parameter int BEAT_W         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat,
    input  logic              frame_start,
    input  logic              btn_next,
    input  logic              btn_hold,
    input  logic              random_mode,
    output logic [SEL_W-1:0]  pattern_sel,
    output logic              pattern_strobe,
    output logic              holding,
    output logic [BEAT_W-1:0] beat_idx
);

    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_PENDING} state_t;

    localparam logic [SEL_W:0]    LP_N         = (SEL_W+1)'(NUM_PATTERNS);
    localparam logic [SEL_W-1:0]  LP_LAST      = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [BEAT_W-1:0] LP_BEAT_LAST = BEAT_W'(BEATS_PER_STEP - 1);

    state_t            r_state;
    logic [BEAT_W-1:0] r_beat_idx;
    logic [SEL_W-1:0]  r_next_sel;
    logic [SEL_W-1:0]  r_pattern_sel;
    logic              r_strobe;
    logic              r_holding;
    logic [7:0]        r_lfsr;
    logic              r_prev_next;
    logic              r_prev_hold;

    state_t            w_state_n;
    logic [BEAT_W-1:0] w_beat_n;
    logic [SEL_W-1:0]  w_next_sel_n;
    logic [SEL_W-1:0]  w_sel_n;
    logic              w_strobe_n;
    logic              w_holding_n;
    logic              w_next_edge;
    logic              w_hold_edge;
    logic              w_expire;
    logic [SEL_W-1:0]  w_seq_next;
    logic [SEL_W-1:0]  w_rnd;
    logic [SEL_W-1:0]  w_next_idx;

    assign w_next_edge = btn_next & ~r_prev_next;
    assign w_hold_edge = btn_hold & ~r_prev_hold;
    assign w_expire    = beat && (r_beat_idx == LP_BEAT_LAST);

    // Random candidate folded once into range, then forced away from the current pattern.
    always_comb begin
        w_seq_next = (r_pattern_sel == LP_LAST) ? '0 : r_pattern_sel + SEL_W'(1);
        w_rnd      = r_lfsr[SEL_W-1:0];
        if ({1'b0, r_lfsr[SEL_W-1:0]} >= LP_N)
            w_rnd = r_lfsr[SEL_W-1:0] - LP_N[SEL_W-1:0];
        if (w_rnd == r_pattern_sel)
            w_rnd = w_seq_next;
        w_next_idx = random_mode ? w_rnd : w_seq_next;
    end

    // holding doubles as the return-to-HOLD flag while a change is pending.
    always_comb begin
        w_state_n    = r_state;
        w_beat_n     = r_beat_idx;
        w_next_sel_n = r_next_sel;
        w_sel_n      = r_pattern_sel;
        w_strobe_n   = 1'b0;
        w_holding_n  = r_holding ^ w_hold_edge;
        case (r_state)
            ST_RUN: begin
                if (w_next_edge || w_expire) begin
                    w_beat_n     = '0;
                    w_next_sel_n = w_next_idx;
                    w_state_n    = ST_PENDING;
                end else if (w_hold_edge) begin
                    w_beat_n  = '0;
                    w_state_n = ST_HOLD;
                end else if (beat) begin
                    w_beat_n = r_beat_idx + BEAT_W'(1);
                end
            end
            ST_HOLD: begin
                if (w_next_edge) begin
                    w_next_sel_n = w_next_idx;
                    w_state_n    = ST_PENDING;
                end else if (w_hold_edge) begin
                    w_state_n = ST_RUN;
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    w_sel_n    = r_next_sel;
                    w_strobe_n = 1'b1;
                    w_state_n  = w_holding_n ? ST_HOLD : ST_RUN;
                end
            end
            default: w_state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_beat_idx    <= '0;
            r_next_sel    <= '0;
            r_pattern_sel <= '0;
            r_strobe      <= 1'b0;
            r_holding     <= 1'b0;
            r_lfsr        <= 8'h01;
            r_prev_next   <= 1'b1;
            r_prev_hold   <= 1'b1;
        end else begin
            r_state       <= w_state_n;
            r_beat_idx    <= w_beat_n;
            r_next_sel    <= w_next_sel_n;
            r_pattern_sel <= w_sel_n;
            r_strobe      <= w_strobe_n;
            r_holding     <= w_holding_n;
            r_lfsr        <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            r_prev_next   <= btn_next;
            r_prev_hold   <= btn_hold;
        end
    end

    assign pattern_sel    = r_pattern_sel;
    assign pattern_strobe = r_strobe;
    assign holding        = r_holding;
    assign beat_idx       = r_beat_idx;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler: directed sequences, a vector table,
// a random-order instance with 5 patterns, and randomized stimulus against a reference model.
module tb_pattern_scheduler;

    localparam int N0  = 8;
    localparam int SW  = 3;
    localparam int BPS = 4;
    localparam int BW  = 4;
    localparam int N1  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, beat = 1'b0, frame_start = 1'b0;
    logic btn_next = 1'b0, btn_hold = 1'b0, random_mode = 1'b0;
    logic [SW-1:0] pattern_sel;
    logic          pattern_strobe, holding;
    logic [BW-1:0] beat_idx;

    logic btn_next1 = 1'b0, random_mode1 = 1'b1, tie0 = 1'b0;
    logic [SW-1:0] sel1;
    logic          strobe1, holding1;
    logic [BW-1:0] beat_idx1;

    pattern_scheduler #(.NUM_PATTERNS(N0), .SEL_W(SW), .BEATS_PER_STEP(BPS), .BEAT_W(BW)) dut (
        .clk(clk), .reset(reset), .beat(beat), .frame_start(frame_start),
        .btn_next(btn_next), .btn_hold(btn_hold), .random_mode(random_mode),
        .pattern_sel(pattern_sel), .pattern_strobe(pattern_strobe),
        .holding(holding), .beat_idx(beat_idx)
    );

    pattern_scheduler #(.NUM_PATTERNS(N1), .SEL_W(SW), .BEATS_PER_STEP(BPS), .BEAT_W(BW)) dut_rnd (
        .clk(clk), .reset(reset), .beat(tie0), .frame_start(frame_start),
        .btn_next(btn_next1), .btn_hold(tie0), .random_mode(random_mode1),
        .pattern_sel(sel1), .pattern_strobe(strobe1),
        .holding(holding1), .beat_idx(beat_idx1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int s, input int st, input int h, input int b);
        check({tag, "_sel"}, int'(pattern_sel), s);
        check({tag, "_strobe"}, int'(pattern_strobe), st);
        check({tag, "_holding"}, int'(holding), h);
        check({tag, "_beat_idx"}, int'(beat_idx), b);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference model: pending flag + target, hold flag and beat count, stepped once per clock.
    int         m_sel = 0, m_strobe = 0, m_hold = 0, m_beats = 0, m_pend = 0, m_target = 0;
    int         m_pn = 1, m_ph = 1;
    logic [7:0] m_lfsr = 8'h01;
    int         m_ne, m_he, m_seq, m_r, m_nxt;

    always @(posedge clk) begin
        if (reset) begin
            m_sel = 0; m_strobe = 0; m_hold = 0; m_beats = 0; m_pend = 0; m_target = 0;
            m_lfsr = 8'h01; m_pn = 1; m_ph = 1;
        end else begin
            m_ne  = (btn_next && m_pn == 0) ? 1 : 0;
            m_he  = (btn_hold && m_ph == 0) ? 1 : 0;
            m_seq = (m_sel + 1) % N0;
            m_r   = int'(m_lfsr) % (1 << SW);
            if (m_r >= N0) m_r = m_r - N0;
            if (m_r == m_sel) m_r = m_seq;
            m_nxt = random_mode ? m_r : m_seq;
            m_strobe = 0;
            if (m_pend != 0) begin
                if (frame_start) begin
                    m_sel = m_target; m_strobe = 1; m_pend = 0;
                end
            end else if (m_ne != 0 || (m_hold == 0 && beat && m_beats == BPS - 1)) begin
                m_target = m_nxt; m_pend = 1; m_beats = 0;
            end else if (m_hold == 0 && beat) begin
                m_beats++;
            end
            if (m_he != 0) begin
                m_hold = 1 - m_hold;
                if (m_hold != 0) m_beats = 0;
            end
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            m_pn = int'(btn_next);
            m_ph = int'(btn_hold);
        end
    end

    typedef struct {
        logic rst, bt, fr, nx, hd;
        int   sel, stb, hld, bi;
    } vec_t;
    vec_t tbl[14];

    int exp_sel, cnt, any_strobe, prev, ok;
    logic [N1-1:0] seen;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 2};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1, 1, 0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 1, 0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 0, 0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0, 0};

        step(); step();
        check_out("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // Four spaced beats then a frame boundary
        for (int i = 1; i <= 4; i++) begin
            beat = 1'b1; step(); beat = 1'b0;
            check("t1_beat_idx", int'(beat_idx), i % 4);
            repeat (99) step();
        end
        check("t1_no_early_sel", int'(pattern_sel), 0);
        check("t1_no_early_strobe", int'(pattern_strobe), 0);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("t1_sel", int'(pattern_sel), 1);
        check("t1_strobe", int'(pattern_strobe), 1);
        step();
        check("t1_strobe_width", int'(pattern_strobe), 0);

        // 32 automatic steps with wrap
        exp_sel = 1; cnt = 0;
        for (int k = 0; k < 32; k++) begin
            repeat (BPS) begin
                beat = 1'b1; step(); beat = 1'b0; step();
            end
            frame_start = 1'b1; step(); frame_start = 1'b0;
            exp_sel = (exp_sel + 1) % N0;
            check("t2_sel", int'(pattern_sel), exp_sel);
            if (pattern_strobe) cnt++;
            step();
            check("t2_strobe_width", int'(pattern_strobe), 0);
        end
        check("t2_strobe_count", cnt, 32);

        // Hold freezes automatic advance; manual next still works
        btn_hold = 1'b1; step(); btn_hold = 1'b0;
        check("t3_holding", int'(holding), 1);
        any_strobe = 0;
        for (int i = 0; i < 10; i++) begin
            beat = 1'b1; step(); beat = 1'b0; any_strobe |= int'(pattern_strobe);
        end
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'b1; step(); frame_start = 1'b0; step();
            any_strobe |= int'(pattern_strobe);
        end
        check_out("t3_frozen", 1, 0, 1, 0);
        check("t3_no_strobe", any_strobe, 0);
        btn_next = 1'b1; step(); btn_next = 1'b0;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check_out("t3_manual", 2, 1, 1, 0);
        btn_hold = 1'b1; step(); btn_hold = 1'b0;
        check("t3_release", int'(holding), 0);

        // Beat expiry, next edge and frame_start all in one cycle
        repeat (3) begin
            beat = 1'b1; step(); beat = 1'b0;
        end
        check("t4_beat3", int'(beat_idx), 3);
        beat = 1'b1; btn_next = 1'b1; frame_start = 1'b1; step();
        beat = 1'b0; btn_next = 1'b0; frame_start = 1'b0;
        check_out("t4_same_cycle", 2, 0, 0, 0);
        step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check_out("t4_commit", 3, 1, 0, 0);
        step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check_out("t4_single", 3, 0, 0, 0);

        // Vector table: hold/next interactions around PENDING
        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst; beat = tbl[i].bt; frame_start = tbl[i].fr;
            btn_next = tbl[i].nx; btn_hold = tbl[i].hd;
            step();
            check_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].stb, tbl[i].hld, tbl[i].bi);
        end
        reset = 1'b0; beat = 1'b0; frame_start = 1'b0; btn_hold = 1'b0;

        // Reset during PENDING with btn_next held through reset
        btn_next = 1'b1; step();
        reset = 1'b1; step(); reset = 1'b0;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check_out("t6_after_reset", 0, 0, 0, 0);
        repeat (3) step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check_out("t6_held_next", 0, 0, 0, 0);
        btn_next = 1'b0; step();

        // Random order with 5 patterns
        prev = int'(sel1); seen = '0;
        for (int i = 0; i < 200; i++) begin
            btn_next1 = 1'b1; step(); btn_next1 = 1'b0;
            frame_start = 1'b1; step(); frame_start = 1'b0;
            ok = (int'(sel1) < N1 && int'(sel1) != prev && strobe1) ? 1 : 0;
            check("t5_rand_step", ok, 1);
            if (int'(sel1) < N1) seen[sel1] = 1'b1;
            prev = int'(sel1);
        end
        check("t5_coverage", int'(seen), (1 << N1) - 1);

        // Randomized stimulus against the reference model
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            beat        = ($urandom_range(0, 3) == 0);
            frame_start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 9) == 0) btn_hold = ~btn_hold;
            if ($urandom_range(0, 49) == 0) random_mode = ~random_mode;
            step();
            check_out("rand", m_sel, m_strobe, m_hold, m_beats);
        end
        reset = 1'b0; beat = 1'b0; frame_start = 1'b0;
        btn_next = 1'b0; btn_hold = 1'b0; random_mode = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_scheduler.md
Name: pattern_scheduler

Overview:
Sequences the active video pattern from the beat pulse produced by the tempo generator. It counts beats and advances the pattern after a programmable number of beats. It also accepts manual next/hold buttons, with sequential or pseudo-random order. Pattern changes are deferred to a frame boundary so the pattern mux never switches mid-frame.

Parameters:
NUM_PATTERNS, 8, number of selectable patterns (2..2^SEL_W)
SEL_W, 3, width of pattern_sel
BEATS_PER_STEP, 4, beats per automatic advance (1..2^BEAT_W-1)
BEAT_W, 4, width of beat counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
beat  in  1  single-cycle pulse from tempo generator
frame_start  in  1  single-cycle pulse at start of vertical blank
btn_next  in  1  level, already synchronised; rising edge = skip to next pattern
btn_hold  in  1  level, already synchronised; rising edge = toggle hold
random_mode  in  1  0 = sequential order, 1 = pseudo-random order
pattern_sel  out  SEL_W  registered active pattern index
pattern_strobe  out  1  one-cycle pulse when pattern_sel changes
holding  out  1  registered; 1 while automatic advance is frozen
beat_idx  out  BEAT_W  registered beats elapsed in current step

Behaviour:
- One clock: clk. Reset is synchronous and active-high on port reset. All state updates on posedge clk.
- Reset values:
  - Outputs: pattern_sel=0, pattern_strobe=0, holding=0, beat_idx=0.
  - Internal: state=RUN, next_sel=0, lfsr=8'h01.
  - Button edge registers reset to 1, so a button held through reset produces no edge.
- Edge detect: next_edge = btn_next & ~prev_next; hold_edge likewise; prev regs track inputs every cycle.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle, including in reset-released idle time. Never reaches 0.
- Next-index function, evaluated at request time from the current pattern_sel:
  - Sequential: sel+1, wrapping to 0 after NUM_PATTERNS-1.
  - Random: r = lfsr[SEL_W-1:0]; if r >= NUM_PATTERNS, r -= NUM_PATTERNS. If r == pattern_sel, r = sequential next. The result always differs from the current pattern.
- States: RUN, HOLD, PENDING. A ret_hold bit records which state to return to after PENDING.
- RUN:
  - beat with beat_idx < BEATS_PER_STEP-1: beat_idx+1.
  - beat with beat_idx == BEATS_PER_STEP-1: beat_idx←0, latch next_sel, ->PENDING (ret_hold=0).
  - next_edge: beat_idx←0, latch next_sel, ->PENDING. If it coincides with beat expiry, only one advance occurs.
- HOLD:
  - beats ignored; beat_idx stays 0.
  - next_edge: latch next_sel, ->PENDING (ret_hold=1).
- PENDING:
  - beats and further next_edge ignored; next_sel does not change.
  - frame_start: pattern_sel←next_sel and pattern_strobe=1 on that edge (visible the following cycle, for exactly one cycle). Return to HOLD if ret_hold, else RUN.
  - A frame_start in the same cycle as the request that enters PENDING is not consumed; the change waits for the next frame_start.
- hold_edge, any state: holding toggles.
  - RUN<->HOLD direct; entering HOLD clears beat_idx.
  - In PENDING, hold_edge toggles ret_hold and holding; the pending change still completes.
  - hold_edge together with next_edge: both take effect (advance queued, hold toggled).
- pattern_strobe is 0 in every cycle except the one after a committed change.
- reset asserted mid-PENDING: pending change discarded; all values return to reset values; no strobe.
- Latency: automatic advance completes at the first frame_start strictly after the BEATS_PER_STEP-th beat. Maximum latency is one frame.

Test Plan:
1. Reset, sequential mode, 4 beats spaced 100 cycles, then frame_start -> beat_idx 1,2,3,0. pattern_sel 0->1 one cycle after frame_start, with a single-cycle pattern_strobe.
2. 32 auto steps in sequential mode with NUM_PATTERNS=8 -> pattern_sel runs 0..7, wraps to 0. Exactly 32 strobes.
3. btn_hold rising, then 10 beats and 3 frame_starts -> holding=1, beat_idx=0, pattern_sel unchanged, no strobe. btn_next rising, then frame_start -> sel+1 and holding still 1.
4. beat expiry and btn_next rise in the same cycle, plus frame_start in that same cycle -> no change that cycle. Next frame_start gives a single +1 advance and one strobe.
5. random_mode=1, NUM_PATTERNS=5, 200 advances -> every pattern_sel in 0..4, never equal to the previous value, every value seen.
6. Enter PENDING, assert reset for 1 cycle, then frame_start -> pattern_sel=0, no strobe. btn_next held high across reset produces no advance after release.
